// File: rtl/ldpc_pkg.sv
// Shared LDPC decoder types, defaults and the symmetric saturation helper.
// Combinational helpers only; no timing or flow control of its own.
package ldpc_pkg;

    localparam int LDPC_WIDTH      = 8;
    localparam int LDPC_COL_WEIGHT = 3;

    localparam logic [2:0] INIT_START = 3'd1;

    typedef enum logic [1:0] {
        VN_IDLE = 2'd0,
        VN_ACC  = 2'd1,
        VN_EMIT = 2'd2
    } vn_state_t;

    // Clamp to +/-(2^(w-1)-1); the most negative code is never produced.
    function automatic logic signed [31:0] sat_to_width(input logic signed [31:0] val,
                                                       input int w);
        logic signed [31:0] lim;
        lim = (32'sd1 <<< (w - 1)) - 32'sd1;
        if (val > lim) begin
            return lim;
        end else if (val < -lim) begin
            return -lim;
        end
        return val;
    endfunction

endpackage

// File: rtl/var_node_if.sv
// Message-stream bundle between a variable node and its driver / downstream row stage.
// Signal bundle only; the slave side owns o_ready, no output backpressure exists.
interface var_node_if #(
    parameter int WIDTH = ldpc_pkg::LDPC_WIDTH
);
    logic signed [WIDTH-1:0] i_llr;
    logic                    i_llr_val;
    logic signed [WIDTH-1:0] i_data;
    logic                    i_val;
    logic [2:0]              i_init;
    logic                    o_ready;
    logic signed [WIDTH-1:0] o_data;
    logic                    o_val;
    logic [2:0]              o_init;
    logic                    o_hard;
    logic                    o_hard_val;

    modport slave (
        input  i_llr, i_llr_val, i_data, i_val, i_init,
        output o_ready, o_data, o_val, o_init, o_hard, o_hard_val
    );

    modport master (
        output i_llr, i_llr_val, i_data, i_val, i_init,
        input  o_ready, o_data, o_val, o_init, o_hard, o_hard_val
    );
endinterface

// File: rtl/vn_sat_sub.sv
// Extrinsic subtract (total - msg) followed by symmetric saturation to WIDTH.
// Purely combinational, zero latency; no flow control.
module vn_sat_sub #(
    parameter int WIDTH     = ldpc_pkg::LDPC_WIDTH,
    parameter int ACC_WIDTH = WIDTH + 2
) (
    input  logic signed [ACC_WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0]     b,
    output logic signed [WIDTH-1:0]     y
);
    import ldpc_pkg::*;

    logic signed [ACC_WIDTH-1:0] b_ext;
    logic signed [ACC_WIDTH-1:0] diff;
    logic signed [31:0]          diff32;

    // The difference is the sum of the remaining terms, so it always fits ACC_WIDTH.
    assign b_ext  = {{(ACC_WIDTH-WIDTH){b[WIDTH-1]}}, b};
    assign diff   = a - b_ext;
    assign diff32 = {{(32-ACC_WIDTH){diff[ACC_WIDTH-1]}}, diff};
    assign y      = WIDTH'(sat_to_width(diff32, WIDTH));

endmodule

// File: rtl/var_node.sv
// Min-sum variable-node column update: accumulate LLR + COL_WEIGHT messages, emit extrinsics.
// First output one cycle after the last accept, one per cycle; o_ready low while emitting.
module var_node #(
    parameter int WIDTH      = ldpc_pkg::LDPC_WIDTH,
    parameter int COL_WEIGHT = ldpc_pkg::LDPC_COL_WEIGHT,
    parameter int ACC_WIDTH  = WIDTH + $clog2(COL_WEIGHT + 1)
) (
    input  logic     clk,
    input  logic     xrst,
    var_node_if.slave bus
);
    import ldpc_pkg::*;

    localparam int CNT_W = $clog2(COL_WEIGHT + 1);
    localparam int IDX_W = $clog2(COL_WEIGHT);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(COL_WEIGHT - 1);
    localparam logic [CNT_W-1:0] CW_CNT   = CNT_W'(COL_WEIGHT);

    vn_state_t state_q, state_d;

    logic signed [WIDTH-1:0]     llr_q;
    logic signed [ACC_WIDTH-1:0] total_q;
    logic [CNT_W-1:0]            cnt_q;
    logic [CNT_W-1:0]            k_q;
    logic signed [WIDTH-1:0]     msg_q [COL_WEIGHT];

    logic signed [WIDTH-1:0]     o_data_q;
    logic                        o_val_q;
    logic [2:0]                  o_init_q;
    logic                        o_hard_q;
    logic                        o_hard_val_q;

    logic llr_load, col_start, col_add, col_last, emit_step, emit_done, ready;

    logic signed [WIDTH-1:0]     llr_eff;
    logic signed [ACC_WIDTH-1:0] llr_ext, data_ext, start_sum, add_sum;
    logic signed [ACC_WIDTH-1:0] sub_a;
    logic signed [WIDTH-1:0]     sub_b, sub_y;

    // A same-cycle LLR load in IDLE is forwarded into the column's first sum.
    assign llr_eff   = (state_q == VN_IDLE && bus.i_llr_val) ? bus.i_llr : llr_q;
    assign llr_ext   = {{(ACC_WIDTH-WIDTH){llr_eff[WIDTH-1]}}, llr_eff};
    assign data_ext  = {{(ACC_WIDTH-WIDTH){bus.i_data[WIDTH-1]}}, bus.i_data};
    assign start_sum = llr_ext + data_ext;
    assign add_sum   = total_q + data_ext;

    // On the final accept the first extrinsic is formed from the not-yet-registered total.
    assign sub_a = col_last ? add_sum  : total_q;
    assign sub_b = col_last ? msg_q[0] : msg_q[k_q[IDX_W-1:0]];

    vn_sat_sub #(
        .WIDTH     (WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_sat_sub (
        .a (sub_a),
        .b (sub_b),
        .y (sub_y)
    );

    always_comb begin
        state_d   = state_q;
        llr_load  = 1'b0;
        col_start = 1'b0;
        col_add   = 1'b0;
        col_last  = 1'b0;
        emit_step = 1'b0;
        emit_done = 1'b0;
        ready     = 1'b1;
        unique case (state_q)
            VN_IDLE: begin
                llr_load = bus.i_llr_val;
                if (bus.i_val && bus.i_init == INIT_START) begin
                    col_start = 1'b1;
                    state_d   = VN_ACC;
                end
            end
            VN_ACC: begin
                if (bus.i_val) begin
                    if (bus.i_init == INIT_START) begin
                        col_start = 1'b1;
                    end else begin
                        col_add = 1'b1;
                        if (cnt_q == LAST_CNT) begin
                            col_last = 1'b1;
                            state_d  = VN_EMIT;
                        end
                    end
                end
            end
            VN_EMIT: begin
                ready = 1'b0;
                if (k_q == CW_CNT) begin
                    emit_done = 1'b1;
                    state_d   = VN_IDLE;
                end else begin
                    emit_step = 1'b1;
                end
            end
            default: state_d = VN_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (xrst) begin
            state_q      <= VN_IDLE;
            llr_q        <= '0;
            total_q      <= '0;
            cnt_q        <= '0;
            k_q          <= '0;
            for (int i = 0; i < COL_WEIGHT; i++) msg_q[i] <= '0;
            o_data_q     <= '0;
            o_val_q      <= 1'b0;
            o_init_q     <= 3'd0;
            o_hard_q     <= 1'b0;
            o_hard_val_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            o_init_q     <= 3'd0;
            o_hard_val_q <= 1'b0;
            if (llr_load) llr_q <= bus.i_llr;
            if (col_start) begin
                msg_q[0] <= bus.i_data;
                total_q  <= start_sum;
                cnt_q    <= CNT_W'(1);
            end
            if (col_add) begin
                msg_q[cnt_q[IDX_W-1:0]] <= bus.i_data;
                total_q <= add_sum;
                cnt_q   <= cnt_q + CNT_W'(1);
            end
            if (col_last) begin
                o_data_q     <= sub_y;
                o_val_q      <= 1'b1;
                o_init_q     <= INIT_START;
                o_hard_q     <= add_sum[ACC_WIDTH-1];
                o_hard_val_q <= 1'b1;
                k_q          <= CNT_W'(1);
            end
            if (emit_step) begin
                o_data_q <= sub_y;
                k_q      <= k_q + CNT_W'(1);
            end
            if (emit_done) begin
                o_data_q <= '0;
                o_val_q  <= 1'b0;
                k_q      <= '0;
            end
        end
    end

    assign bus.o_ready    = ready;
    assign bus.o_data     = o_data_q;
    assign bus.o_val      = o_val_q;
    assign bus.o_init     = o_init_q;
    assign bus.o_hard     = o_hard_q;
    assign bus.o_hard_val = o_hard_val_q;

endmodule

// File: doc/var_node.md
# var_node

Variable-node (column) update stage of the LDPC min-sum decoder, directly upstream of the check-node `row` stage. It latches one channel LLR and accumulates `COL_WEIGHT` incoming check-to-variable messages, buffering each one. It then emits `COL_WEIGHT` extrinsic variable-to-check messages, one per cycle, each equal to the total minus the message from that edge. It also produces a hard bit decision. Its output stream drives the `row` inputs directly: `o_data` → `i_data`, `o_val` → `i_val`, `o_init` → `i_init`.

## Interface
- `WIDTH`, 8: message/LLR width, two's complement.
- `COL_WEIGHT`, 3: number of edges per column (≥2).
- `ACC_WIDTH`, `WIDTH+$clog2(COL_WEIGHT+1)`: accumulator width.

- `clk`  in  1  clock; all logic on the rising edge.
- `xrst`  in  1  reset; one clock; reset is synchronous and active-high.
- `i_llr`  in  WIDTH  channel LLR.
- `i_llr_val`  in  1  loads `i_llr` (IDLE only).
- `i_data`  in  WIDTH  check-to-variable message.
- `i_val`  in  1  `i_data` valid.
- `i_init`  in  3  `3'd1` marks the first message of a column.
- `o_ready`  out  1  high in IDLE/ACC; messages are accepted only while high.
- `o_data`  out  WIDTH  extrinsic message, registered.
- `o_val`  out  1  `o_data` valid.
- `o_init`  out  3  `3'd1` with the first emitted message, else `3'd0`.
- `o_hard`  out  1  hard decision, 1 if total < 0.
- `o_hard_val`  out  1  one-cycle pulse, `o_hard` valid.

## Operation
- States: IDLE, ACC, EMIT.
- IDLE:
  - `i_llr_val` loads the LLR register.
  - `i_val` with `i_init==1`: store msg[0], total = LLR + msg, cnt = 1, go to ACC.
  - `i_val` with any other `i_init` is ignored.
- ACC:
  - `i_val` with `i_init!=1`: store msg[cnt], total += msg, cnt++.
  - On the `COL_WEIGHT`-th accept, go to EMIT with k = 0.
  - `i_val` with `i_init==1` restarts the column: msg[0] overwritten, total = LLR + msg, cnt = 1.
  - `i_llr_val` is ignored.
- EMIT:
  - One output per cycle: `o_data` = sat(total − msg[k]), k = 0..`COL_WEIGHT`−1.
  - After the last output, return to IDLE.
  - `o_ready` = 0; all inputs are ignored.
- Arithmetic:
  - Sign-extend to `ACC_WIDTH` before summing; no internal overflow is possible.
  - Saturate to the symmetric range ±(2^(WIDTH−1)−1), i.e. ±127 at WIDTH = 8.
  - An input of −2^(WIDTH−1) is used as-is.
- `o_hard` = sign bit of the final total.
- The LLR is held across columns until reloaded.
- No output backpressure: the downstream stage must accept one message per cycle.

## Timing
- Reset values: `o_data`=0, `o_val`=0, `o_init`=0, `o_hard`=0, `o_hard_val`=0, `o_ready`=1. LLR register, total and cnt = 0; state = IDLE.
- Last message accepted at cycle t:
  - `o_val` is high for cycles t+1 … t+`COL_WEIGHT`.
  - `o_init`=1 and `o_hard_val`=1 at t+1 only.
  - `o_ready` returns high at t+`COL_WEIGHT`+1.
- `i_llr_val` and `i_val` in the same IDLE cycle: the new LLR is used in that cycle's total (forwarded).
- `xrst` mid-ACC or mid-EMIT: all state and outputs return to reset values on the next edge. No partial output follows.
- `o_val` is low in every cycle outside EMIT.

## Structure
- Shared package `ldpc_pkg` holds:
  - `WIDTH` and `COL_WEIGHT` defaults;
  - `INIT_START = 3'd1`;
  - state enum `vn_state_t`;
  - the `sat_to_width` function.
- One sub-module, `vn_sat_sub`: combinational `ACC_WIDTH` subtract plus symmetric saturation to `WIDTH`.
- Message buffer: `COL_WEIGHT` × `WIDTH` register array in `var_node`.

## Test plan
- Nominal (WIDTH=8, COL_WEIGHT=3): LLR=10, msgs 5, −3, 7 → `o_data` 14, 22, 12. `o_init`=1 on the first only; `o_hard`=0.
- Positive saturation: LLR=100, msgs 100, 100, −2 → 127, 127, 127; `o_hard`=0.
- Negative saturation: LLR=−100, msgs −100, −100, 5 → −127, −127, −127; `o_hard`=1.
- Restart: LLR=0, msgs 4 (init=1), 9, then 1 (init=1), 2, 3 → column totals 6; outputs 5, 4, 3.
- Handshake: `i_val` pulses during EMIT are dropped and `o_ready`=0 there. Back-to-back columns are separated by exactly 0 idle cycles after `o_ready` rises.
- Reset: assert `xrst` at the 2nd EMIT cycle → the next cycle has `o_val`=0 and `o_ready`=1, with no residual outputs afterwards.
